aes_key_expand: RTL and testbench

Iterative AES-128 key-schedule stage that sits directly upstream of the `aes` core's round logic. It accepts a 128-bit cipher key over a valid/ready handshake and computes one round key per clock into an internal 11-entry round-key file. It then serves those keys to the core through a registered random-access read port. The core or the bench waits for `keys_valid` before starting a cipher operation that uses the keys.

---
 rtl/aes_key_expand.sv | 130 +++++++++++++
 tb/tb_aes_key_expand.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/aes_key_expand.sv
// rtl/aes_key_expand.sv - Iterative AES-128 key schedule with an 11-entry round-key file and registered read port.

module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  // Forward S-box table, entry 0 in the top byte; {~a,3'b000} is (255-a)*8.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign y = SBOX[{~a, 3'b000} +: 8];
endmodule

module aes_key_expand #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         resetL,
  input  logic [127:0] key_in,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [3:0]   rk_addr,
  output logic [127:0] rk_data,
  output logic         keys_valid,
  output logic         busy
);
  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

  localparam logic [3:0] LAST = 4'(NR);

  state_t        state_q, state_d;
  logic [3:0]    round_q, round_d;
  logic [7:0]    rcon_q, rcon_d;
  logic [127:0]  rk_q [0:NR];
  logic [127:0]  rk_d [0:NR];
  logic [127:0]  rk_data_q, rk_data_d;
  logic          keys_valid_q, keys_valid_d;

  logic [3:0]    round_m1;
  logic [127:0]  prev_rk;
  logic [31:0]   w0, w1, w2, w3, rot_w3, sub_w3, t;
  logic [31:0]   n0, n1, n2, n3;
  logic [7:0]    rcon_next;
  logic          accept;

  assign key_ready  = (state_q != EXPAND);
  assign busy       = (state_q == EXPAND);
  assign keys_valid = keys_valid_q;
  assign rk_data    = rk_data_q;
  assign accept     = key_valid && key_ready;

  assign round_m1 = round_q - 4'd1;
  assign prev_rk  = rk_q[round_m1];
  assign {w0, w1, w2, w3} = prev_rk;
  assign rot_w3   = {w3[23:0], w3[31:24]};

  for (genvar b = 0; b < 4; b++) begin : g_sub
    aes_sbox u_sbox (
      .a (rot_w3[8*b +: 8]),
      .y (sub_w3[8*b +: 8])
    );
  end

  assign t  = sub_w3 ^ {rcon_q, 24'h0};
  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;
  assign rcon_next = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);

  always_comb begin
    state_d      = state_q;
    round_d      = round_q;
    rcon_d       = rcon_q;
    keys_valid_d = keys_valid_q;
    rk_d         = rk_q;

    case (state_q)
      EXPAND: begin
        for (int i = 1; i <= NR; i++) begin
          if (round_q == 4'(i)) rk_d[i] = {n0, n1, n2, n3};
        end
        round_d = round_q + 4'd1;
        rcon_d  = rcon_next;
        if (round_q == LAST) begin
          state_d      = DONE;
          keys_valid_d = 1'b1;
        end
      end
      default: begin
        if (accept) begin
          rk_d[0]      = key_in;
          round_d      = 4'd1;
          rcon_d       = 8'h01;
          keys_valid_d = 1'b0;
          state_d      = EXPAND;
        end
      end
    endcase

    // Read uses pre-update contents, so a same-edge write is not bypassed.
    rk_data_d = (rk_addr <= LAST) ? rk_q[rk_addr] : 128'h0;
  end

  always_ff @(posedge clk or negedge resetL) begin
    if (!resetL) begin
      state_q      <= IDLE;
      round_q      <= 4'd0;
      rcon_q       <= 8'h01;
      keys_valid_q <= 1'b0;
      rk_data_q    <= 128'h0;
      for (int i = 0; i <= NR; i++) rk_q[i] <= 128'h0;
    end else begin
      state_q      <= state_d;
      round_q      <= round_d;
      rcon_q       <= rcon_d;
      keys_valid_q <= keys_valid_d;
      rk_data_q    <= rk_data_d;
      for (int i = 0; i <= NR; i++) rk_q[i] <= rk_d[i];
    end
  end
endmodule

// File: tb/tb_aes_key_expand.sv
// tb/tb_aes_key_expand.sv - Directed-vector bench for aes_key_expand using FIPS-197 key schedules.

module tb_aes_key_expand;
  logic         clk = 1'b0;
  logic         resetL;
  logic [127:0] key_in;
  logic         key_valid;
  logic         key_ready;
  logic [3:0]   rk_addr;
  logic [127:0] rk_data;
  logic         keys_valid;
  logic         busy;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [127:0] KA1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KZ   = 128'h0;
  localparam logic [127:0] A1_1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] A1_10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] Z_1   = 128'h62636363626363636263636362636363;
  localparam logic [127:0] Z_10  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  typedef struct {
    logic [127:0] key;
    logic [3:0]   addr;
    logic [127:0] exp;
  } vec_t;

  vec_t tbl [27];

  aes_key_expand #(.NR(10)) dut (
    .clk        (clk),
    .resetL     (resetL),
    .key_in     (key_in),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .rk_addr    (rk_addr),
    .rk_data    (rk_data),
    .keys_valid (keys_valid),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic read_rk(input logic [3:0] a, input logic [127:0] exp, input string nm);
    @(negedge clk);
    rk_addr = a;
    @(posedge clk);
    #1;
    check($sformatf("%s rk[%0d]", nm, a), rk_data, exp);
  endtask

  // Handshake from IDLE/DONE, then measure latency and busy duration.
  task automatic load_key(input logic [127:0] k, input string nm);
    int cycles;
    int busy_cnt;
    @(negedge clk);
    key_in    = k;
    key_valid = 1'b1;
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    check({nm, " busy after accept"}, 128'(busy), 128'd1);
    check({nm, " keys_valid after accept"}, 128'(keys_valid), 128'd0);
    cycles   = 0;
    busy_cnt = 1;
    while (cycles < 20 && !keys_valid) begin
      @(posedge clk);
      #1;
      cycles++;
      if (busy) busy_cnt++;
    end
    check({nm, " expansion latency"}, 128'(cycles), 128'd10);
    check({nm, " busy cycles"}, 128'(busy_cnt), 128'd10);
  endtask

  initial begin
    int ready_hi;
    int w;

    tbl[0]  = '{KZ, 4'd0,  KZ};
    tbl[1]  = '{KZ, 4'd1,  Z_1};
    tbl[2]  = '{KZ, 4'd2,  128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa};
    tbl[3]  = '{KZ, 4'd3,  128'h90973450696ccffaf2f457330b0fac99};
    tbl[4]  = '{KZ, 4'd4,  128'hee06da7b876a1581759e42b27e91ee2b};
    tbl[5]  = '{KZ, 4'd5,  128'h7f2e2b88f8443e098dda7cbbf34b9290};
    tbl[6]  = '{KZ, 4'd6,  128'hec614b851425758c99ff09376ab49ba7};
    tbl[7]  = '{KZ, 4'd7,  128'h217517873550620bacaf6b3cc61bf09b};
    tbl[8]  = '{KZ, 4'd8,  128'h0ef903333ba9613897060a04511dfa9f};
    tbl[9]  = '{KZ, 4'd9,  128'hb1d4d8e28a7db9da1d7bb3de4c664941};
    tbl[10] = '{KZ, 4'd10, Z_10};
    tbl[11] = '{KA1, 4'd0,  KA1};
    tbl[12] = '{KA1, 4'd1,  A1_1};
    tbl[13] = '{KA1, 4'd2,  128'hf2c295f27a96b9435935807a7359f67f};
    tbl[14] = '{KA1, 4'd3,  128'h3d80477d4716fe3e1e237e446d7a883b};
    tbl[15] = '{KA1, 4'd4,  128'hef44a541a8525b7fb671253bdb0bad00};
    tbl[16] = '{KA1, 4'd5,  128'hd4d1c6f87c839d87caf2b8bc11f915bc};
    tbl[17] = '{KA1, 4'd6,  128'h6d88a37a110b3efddbf98641ca0093fd};
    tbl[18] = '{KA1, 4'd7,  128'h4e54f70e5f5fc9f384a64fb24ea6dc4f};
    tbl[19] = '{KA1, 4'd8,  128'head27321b58dbad2312bf5607f8d292f};
    tbl[20] = '{KA1, 4'd9,  128'hac7766f319fadc2128d12941575c006e};
    tbl[21] = '{KA1, 4'd10, A1_10};
    tbl[22] = '{KA1, 4'd11, 128'h0};
    tbl[23] = '{KA1, 4'd12, 128'h0};
    tbl[24] = '{KA1, 4'd13, 128'h0};
    tbl[25] = '{KA1, 4'd14, 128'h0};
    tbl[26] = '{KA1, 4'd15, 128'h0};

    resetL    = 1'b0;
    key_in    = 128'h0;
    key_valid = 1'b0;
    rk_addr   = 4'd0;
    #2;
    check("reset key_ready", 128'(key_ready), 128'd1);
    check("reset busy", 128'(busy), 128'd0);
    check("reset keys_valid", 128'(keys_valid), 128'd0);
    check("reset rk_data", rk_data, 128'h0);
    @(negedge clk);
    resetL = 1'b1;

    // Vector table: load each key once, then read and compare every listed entry.
    for (int i = 0; i < 27; i++) begin
      if (i == 0 || tbl[i].key !== tbl[i-1].key) load_key(tbl[i].key, "table");
      read_rk(tbl[i].addr, tbl[i].exp, "table");
    end

    // Second key held during EXPAND must wait for DONE.
    @(negedge clk);
    key_in    = KZ;
    key_valid = 1'b1;
    rk_addr   = 4'd10;
    @(posedge clk);
    #1;
    check("block first accept keys_valid", 128'(keys_valid), 128'd0);
    check("block first accept key_ready", 128'(key_ready), 128'd0);
    key_in   = KA1;
    ready_hi = 0;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk);
      #1;
      if (c < 10 && key_ready) ready_hi++;
    end
    check("block key_ready during expand", 128'(ready_hi), 128'd0);
    check("block keys_valid at done", 128'(keys_valid), 128'd1);
    check("block key_ready at done", 128'(key_ready), 128'd1);
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    check("block keys_valid falls", 128'(keys_valid), 128'd0);
    check("block busy second", 128'(busy), 128'd1);
    check("block first key rk10", rk_data, Z_10);
    w = 0;
    while (w < 20 && !keys_valid) begin
      @(posedge clk);
      #1;
      w++;
    end
    check("block second wait", 128'(keys_valid), 128'd1);
    read_rk(4'd10, A1_10, "block second");

    // Asynchronous reset in the middle of an expansion.
    @(negedge clk);
    key_in    = KA1;
    key_valid = 1'b1;
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    resetL = 1'b0;
    #1;
    check("midreset keys_valid", 128'(keys_valid), 128'd0);
    check("midreset busy", 128'(busy), 128'd0);
    check("midreset key_ready", 128'(key_ready), 128'd1);
    check("midreset rk_data", rk_data, 128'h0);
    @(negedge clk);
    resetL = 1'b1;
    for (int a = 0; a <= 10; a++) read_rk(4'(a), 128'h0, "midreset");
    load_key(KA1, "rerun");
    read_rk(4'd10, A1_10, "rerun");
    read_rk(4'd0, KA1, "rerun");
    read_rk(4'd1, A1_1, "rerun");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
